pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_ctrl_pkg.sv | 47 ++++
 rtl/pwm_fade_ctrl_if.sv | 9 +
 rtl/fade_prescaler.sv | 33 +++
 rtl/pwm_fade_ctrl.sv | 132 +++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM fade controller: the register map, the ctrl
// bit positions, the FSM state encoding and the single-step duty arithmetic.
package pwm_ctrl_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI  = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI  = 7'h03;
    localparam logic [6:0] ADDR_DUTY       = 7'h04;
    localparam logic [6:0] ADDR_TARGET     = 7'h05;
    localparam logic [6:0] ADDR_STEP       = 7'h06;
    localparam logic [6:0] ADDR_PRESCALE   = 7'h07;
    localparam logic [6:0] ADDR_CTRL       = 7'h08;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_LOOP_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_STEP = 2'd2
    } fade_state_t;

    // One fade step: land on the target when it is within reach, otherwise
    // move by the effective step (a zero step means 1). The arithmetic is
    // 9-bit, and a carry or borrow clamps the result to the rail.
    function automatic logic [7:0] fade_step_toward(input logic [7:0] duty,
                                                    input logic [7:0] target,
                                                    input logic [7:0] step);
        logic [8:0] eff;
        logic [8:0] diff;
        logic [8:0] sum;
        logic [8:0] dif;
        eff  = (step == 8'd0) ? 9'd1 : {1'b0, step};
        diff = (target >= duty) ? ({1'b0, target} - {1'b0, duty})
                                : ({1'b0, duty} - {1'b0, target});
        sum  = {1'b0, duty} + eff;
        dif  = {1'b0, duty} - eff;
        if (diff <= eff)
            return target;
        else if (target > duty)
            return sum[8] ? 8'hFF : sum[7:0];
        else
            return dif[8] ? 8'h00 : dif[7:0];
    endfunction

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Host register-write bus from the SPI block into the fade controller.
interface pwm_fade_ctrl_if;
    logic       host_wr;
    logic [6:0] host_addr;
    logic [7:0] host_wdata;

    modport master (output host_wr, output host_addr, output host_wdata);
    modport slave  (input  host_wr, input  host_addr, input  host_wdata);
endinterface

// File: rtl/fade_prescaler.sv
// Fade prescaler: a free-running modulo-(prescale+1)*PRESCALE_UNIT down
// counter. tick marks the last clock of each period; the period value is
// re-read from prescale at every wrap, so a new prescale applies from the
// next period on.
module fade_prescaler #(
    parameter int PRESCALE_UNIT = 256,
    parameter int PRESCALE_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       enable,
    input  logic [7:0] prescale,
    output logic       tick
);
    logic [PRESCALE_W-1:0] count;
    logic [PRESCALE_W-1:0] reload;

    assign reload = PRESCALE_W'((32'(prescale) + 32'd1) * 32'(PRESCALE_UNIT) - 32'd1);
    assign tick   = enable && (count == '0);

    // Period counter: load restarts the period, otherwise count down and wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // right-hand side reads the value from before this clock edge.
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= reload;
        else if (enable)
            count <= (count == '0) ? reload : count - PRESCALE_W'(1);
    end
endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM fade controller: host register file plus a WAIT/STEP fade engine that
// walks pwm_duty_cycle toward fade_target once per prescale period.
// Optional feature: define PWM_FADE_LOOP_EN to enable loop (triangle) mode
// through ctrl bit1; without it bit1 always reads back as 0.
module pwm_fade_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int PRESCALE_UNIT = 256,
    parameter int PRESCALE_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pwm_fade_ctrl_if.slave        host,
    output logic [7:0]            en_reg_out_7_0,
    output logic [7:0]            en_reg_out_15_8,
    output logic [7:0]            en_reg_pwm_7_0,
    output logic [7:0]            en_reg_pwm_15_8,
    output logic [7:0]            pwm_duty_cycle,
    output logic                  busy,
    output logic                  done
);
    fade_state_t state;
    logic [7:0]  fade_target;
    logic [7:0]  fade_step;
    logic [7:0]  fade_prescale;
    logic [1:0]  ctrl;
`ifdef PWM_FADE_LOOP_EN
    logic [7:0]  origin;
`endif
    logic        start_req;
    logic        tick;
    logic [7:0]  step_next;

    assign start_req = host.host_wr && (host.host_addr == ADDR_CTRL)
                       && host.host_wdata[CTRL_START_BIT];
    assign step_next = fade_step_toward(pwm_duty_cycle, fade_target, fade_step);
    assign busy      = (state != ST_IDLE);

    fade_prescaler #(
        .PRESCALE_UNIT(PRESCALE_UNIT),
        .PRESCALE_W   (PRESCALE_W)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (start_req),
        .enable  (busy),
        .prescale(fade_prescale),
        .tick    (tick)
    );

    // Fade FSM and register file; host writes come last so they win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
            fade_target     <= 8'h00;
            fade_step       <= 8'h00;
            fade_prescale   <= 8'h00;
            ctrl            <= 2'b00;
            done            <= 1'b0;
`ifdef PWM_FADE_LOOP_EN
            origin          <= 8'h00;
`endif
        end else begin
            done <= 1'b0;

            case (state)
                ST_IDLE: ;
                ST_WAIT: if (tick && ctrl[CTRL_START_BIT]) state <= ST_STEP;
                ST_STEP: begin
                    pwm_duty_cycle <= step_next;
                    if (step_next != fade_target) begin
                        state <= ST_WAIT;
                    end else if (ctrl[CTRL_LOOP_BIT]) begin
`ifdef PWM_FADE_LOOP_EN
                        fade_target <= origin;
                        origin      <= fade_target;
`endif
                        state <= ST_WAIT;
                    end else begin
                        done                 <= 1'b1;
                        ctrl[CTRL_START_BIT] <= 1'b0;
                        state                <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // NOTE: these assignments follow the FSM on purpose; the last
            // non-blocking assignment to a register wins, which gives the
            // host priority over a same-cycle STEP.
            if (host.host_wr) begin
                case (host.host_addr)
                    ADDR_EN_OUT_LO: en_reg_out_7_0  <= host.host_wdata;
                    ADDR_EN_OUT_HI: en_reg_out_15_8 <= host.host_wdata;
                    ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= host.host_wdata;
                    ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= host.host_wdata;
                    ADDR_DUTY: begin
                        pwm_duty_cycle <= host.host_wdata;
                        done           <= 1'b0;
                        state          <= ST_IDLE;
                    end
                    ADDR_TARGET:   fade_target   <= host.host_wdata;
                    ADDR_STEP:     fade_step     <= host.host_wdata;
                    ADDR_PRESCALE: fade_prescale <= host.host_wdata;
                    ADDR_CTRL: begin
                        ctrl[CTRL_START_BIT] <= host.host_wdata[CTRL_START_BIT];
`ifdef PWM_FADE_LOOP_EN
                        ctrl[CTRL_LOOP_BIT]  <= host.host_wdata[CTRL_LOOP_BIT];
`else
                        ctrl[CTRL_LOOP_BIT]  <= 1'b0;
`endif
                        done <= 1'b0;
                        if (host.host_wdata[CTRL_START_BIT]) begin
`ifdef PWM_FADE_LOOP_EN
                            origin <= pwm_duty_cycle;
`endif
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: a register-write vector table, hand
// sequences for the fade corner cases, and randomized fades compared against
// a step-list reference model (step k lands (k+1)*period+1 clocks after the
// start write; the extra clock is the start edge itself).
module tb_pwm_fade_ctrl;
    import pwm_ctrl_pkg::*;

    localparam int UNIT = 256;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic [7:0] en0;
        logic [7:0] en1;
        logic [7:0] en2;
        logic [7:0] en3;
        logic [7:0] duty;
    } reg_vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
    logic       busy, done;

    pwm_fade_ctrl_if host_bus ();

    pwm_fade_ctrl #(.PRESCALE_UNIT(UNIT), .PRESCALE_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host           (host_bus),
        .en_reg_out_7_0 (en_out_lo),
        .en_reg_out_15_8(en_out_hi),
        .en_reg_pwm_7_0 (en_pwm_lo),
        .en_reg_pwm_15_8(en_pwm_hi),
        .pwm_duty_cycle (duty),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_q[$];
    bit exp_ends;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step_clk();
        @(negedge clk);
        cyc++;
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) step_clk();
    endtask

    // Called at a falling edge; the write is sampled at the next rising edge.
    task automatic write_reg(input logic [6:0] addr, input logic [7:0] data);
        host_bus.host_addr  = addr;
        host_bus.host_wdata = data;
        host_bus.host_wr    = 1'b1;
        step_clk();
        host_bus.host_wr    = 1'b0;
    endtask

    task automatic start_fade(input logic [7:0] d, input logic [7:0] t, input logic [7:0] s,
                              input logic [7:0] p, input logic [7:0] c);
        write_reg(ADDR_DUTY, d);
        write_reg(ADDR_TARGET, t);
        write_reg(ADDR_STEP, s);
        write_reg(ADDR_PRESCALE, p);
        write_reg(ADDR_CTRL, c);
        cyc = 0;
    endtask

    // Reference model: the list of duty values the fade visits, one per step.
    function automatic void build_expected(input logic [7:0] d0, input logic [7:0] t0,
                                           input logic [7:0] s, input bit loop_on,
                                           input int max_len);
        int d, t, org, eff, diff, tmp;
        d = int'(d0);
        t = int'(t0);
        org = d;
        eff = (s == 8'd0) ? 1 : int'(s);
        exp_q.delete();
        exp_ends = 1'b0;
        for (int i = 0; i < max_len; i++) begin
            diff = (t > d) ? t - d : d - t;
            if (diff <= eff) d = t;
            else if (t > d)  d = d + eff;
            else             d = d - eff;
            exp_q.push_back(d);
            if (d == t) begin
                if (loop_on) begin
                    tmp = t;
                    t   = org;
                    org = tmp;
                end else begin
                    exp_ends = 1'b1;
                    break;
                end
            end
        end
    endfunction

    task automatic run_expected(input logic [7:0] start_duty, input int n);
        int  prev;
        int  tt;
        bit  last;
        prev = int'(start_duty);
        foreach (exp_q[k]) begin
            tt = (k + 1) * n + 1;
            tick_to(tt - 1);
            check("hold_before_step", 32'(duty), 32'(prev));
            tick_to(tt);
            last = exp_ends && (k == exp_q.size() - 1);
            check("step_duty", 32'(duty), 32'(exp_q[k]));
            check("step_done", 32'(done), 32'(last));
            check("step_busy", 32'(busy), 32'(!last));
            prev = exp_q[k];
        end
        if (exp_ends) begin
            step_clk();
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_after_done", 32'(busy), 32'd0);
            check("duty_held", 32'(duty), 32'(prev));
        end
    endtask

    task automatic idle_watch(input int n, output int done_hits, output int duty_moves);
        logic [7:0] d0;
        d0 = duty;
        done_hits  = 0;
        duty_moves = 0;
        for (int i = 0; i < n; i++) begin
            step_clk();
            if (done)      done_hits++;
            if (duty != d0) duty_moves++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_en_out_lo"}, 32'(en_out_lo), 32'd0);
        check({tag, "_en_out_hi"}, 32'(en_out_hi), 32'd0);
        check({tag, "_en_pwm_lo"}, 32'(en_pwm_lo), 32'd0);
        check({tag, "_en_pwm_hi"}, 32'(en_pwm_hi), 32'd0);
        check({tag, "_duty"},      32'(duty),      32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reg_vec_t   vecs[9];
        int         hits, moves;
        logic [7:0] d, t, s, p;

        vecs[0] = '{7'h00, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{7'h01, 8'h3C, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{7'h02, 8'hFF, 8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h00};
        vecs[3] = '{7'h03, 8'h01, 8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h00};
        vecs[4] = '{7'h09, 8'h77, 8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h00};
        vecs[5] = '{7'h7F, 8'h55, 8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h00};
        vecs[6] = '{7'h04, 8'h42, 8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h42};
        vecs[7] = '{7'h00, 8'h5A, 8'h5A, 8'h3C, 8'hFF, 8'h01, 8'h42};
        vecs[8] = '{7'h06, 8'h00, 8'h5A, 8'h3C, 8'hFF, 8'h01, 8'h42};

        host_bus.host_wr    = 1'b0;
        host_bus.host_addr  = 7'h00;
        host_bus.host_wdata = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("in_reset");
        rst_n = 1'b1;
        step_clk();
        check_outputs_zero("after_reset");

        // Register map, including ignored addresses.
        for (int i = 0; i < 9; i++) begin
            write_reg(vecs[i].addr, vecs[i].data);
            check("vec_en_out_lo", 32'(en_out_lo), 32'(vecs[i].en0));
            check("vec_en_out_hi", 32'(en_out_hi), 32'(vecs[i].en1));
            check("vec_en_pwm_lo", 32'(en_pwm_lo), 32'(vecs[i].en2));
            check("vec_en_pwm_hi", 32'(en_pwm_hi), 32'(vecs[i].en3));
            check("vec_duty",      32'(duty),      32'(vecs[i].duty));
            check("vec_busy",      32'(busy),      32'd0);
        end

        // Ramp up 0x10 -> 0x40 in steps of 0x10.
        start_fade(8'h10, 8'h40, 8'h10, 8'h00, 8'h01);
        check("start_busy", 32'(busy), 32'd1);
        build_expected(8'h10, 8'h40, 8'h10, 1'b0, 16);
        run_expected(8'h10, UNIT);

        // Saturating ramp down 0x05 -> 0x00 with step 0x08.
        start_fade(8'h05, 8'h00, 8'h08, 8'h00, 8'h01);
        build_expected(8'h05, 8'h00, 8'h08, 1'b0, 16);
        run_expected(8'h05, UNIT);

        // Zero step behaves as a step of one.
        start_fade(8'h00, 8'h03, 8'h00, 8'h00, 8'h01);
        build_expected(8'h00, 8'h03, 8'h00, 1'b0, 16);
        run_expected(8'h00, UNIT);

        // Target already reached: completes at the first STEP.
        start_fade(8'h33, 8'h33, 8'h04, 8'h00, 8'h01);
        build_expected(8'h33, 8'h33, 8'h04, 1'b0, 16);
        run_expected(8'h33, UNIT);

`ifdef PWM_FADE_LOOP_EN
        // Loop mode: triangle between 0x00 and 0x20, then stop.
        start_fade(8'h00, 8'h20, 8'h10, 8'h00, 8'h03);
        build_expected(8'h00, 8'h20, 8'h10, 1'b1, 5);
        run_expected(8'h00, UNIT);
        tick_to(cyc + 30);
        write_reg(ADDR_CTRL, 8'h00);
        check("loop_stop_busy", 32'(busy), 32'd0);
        check("loop_stop_duty", 32'(duty), 32'h10);
        idle_watch(UNIT + 20, hits, moves);
        check("loop_stop_done_hits", 32'(hits), 32'd0);
        check("loop_stop_duty_moves", 32'(moves), 32'd0);
`else
        // Loop bit is ignored: the fade is one-shot and pulses done.
        start_fade(8'h00, 8'h20, 8'h10, 8'h00, 8'h03);
        build_expected(8'h00, 8'h20, 8'h10, 1'b0, 16);
        run_expected(8'h00, UNIT);
`endif

        // Host duty write in the same cycle as a STEP.
        start_fade(8'h10, 8'h80, 8'h10, 8'h00, 8'h01);
        tick_to(UNIT + 1);
        check("ovr_first_step", 32'(duty), 32'h20);
        tick_to(2 * UNIT);
        check("ovr_busy_before", 32'(busy), 32'd1);
        write_reg(ADDR_DUTY, 8'h80);
        check("ovr_duty", 32'(duty), 32'h80);
        check("ovr_busy", 32'(busy), 32'd0);
        check("ovr_done", 32'(done), 32'd0);
        idle_watch(UNIT + 10, hits, moves);
        check("ovr_done_hits", 32'(hits), 32'd0);
        check("ovr_duty_moves", 32'(moves), 32'd0);

        // Restart mid-fade from the current duty, then stop with ctrl=0.
        start_fade(8'h00, 8'hF0, 8'h10, 8'h00, 8'h01);
        build_expected(8'h00, 8'hF0, 8'h10, 1'b0, 1);
        run_expected(8'h00, UNIT);
        tick_to(cyc + 40);
        write_reg(ADDR_CTRL, 8'h01);
        cyc = 0;
        check("restart_busy", 32'(busy), 32'd1);
        build_expected(8'h10, 8'hF0, 8'h10, 1'b0, 2);
        run_expected(8'h10, UNIT);
        tick_to(cyc + 20);
        write_reg(ADDR_CTRL, 8'h00);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_duty", 32'(duty), 32'h30);
        check("stop_done", 32'(done), 32'd0);
        idle_watch(UNIT + 20, hits, moves);
        check("stop_done_hits", 32'(hits), 32'd0);
        check("stop_duty_moves", 32'(moves), 32'd0);

        // Randomized one-shot fades; the first uses a longer prescale.
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom_range(0, 255));
            t = 8'($urandom_range(0, 255));
            s = 8'($urandom_range(32, 255));
            p = (i == 0) ? 8'h01 : 8'h00;
            start_fade(d, t, s, p, 8'h01);
            build_expected(d, t, s, 1'b0, 64);
            run_expected(d, (int'(p) + 1) * UNIT);
        end

        // Reset in the middle of a WAIT.
        write_reg(ADDR_EN_OUT_LO, 8'h11);
        start_fade(8'h10, 8'h80, 8'h10, 8'h00, 8'h01);
        tick_to(40);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        step_clk();
        rst_n = 1'b1;
        idle_watch(UNIT + 20, hits, moves);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_duty", 32'(duty), 32'd0);
        check("post_reset_done_hits", 32'(hits), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
